// File: rtl/present_test_pkg.sv
// Shared types and defaults for the PRESENT test sequencer.
// Holds the FSM state encoding and the default select width and timeout.
package present_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_WAIT = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int SEL_W_DEF   = 6;
   // Apparatus budget: four cycles per round is ample for one vector.
   localparam int ROUNDS      = 64;
   localparam int TIMEOUT_DEF = 4 * ROUNDS;

   // Timer must count up to the larger of the wait window and the gap length.
   function automatic int tmr_width(input int timeout, input int gap);
      int span;
      span = (timeout > gap) ? timeout : gap + 1;
      return $clog2(span + 1);
   endfunction

endpackage

// File: rtl/present_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module present_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] cnt_r;

   // Count register: holds at the all-ones value instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (inc && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/present_test_sequencer.sv
// On-chip driver for the PRESENT test apparatus: steps vectors, pulses load, waits for valid.
// Optional macro SEQ_LOOP_EN: DONE lasts one cycle and the pass restarts until abort.
module present_test_sequencer
   import present_test_pkg::*;
#(
   parameter int NUM_SEQ    = 32,
   parameter int SEL_W      = SEL_W_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int GAP_CYCLES = 2,
   parameter int CNT_W      = 8
) (
   input  logic             sig_mstr_clk,
   input  logic             sig_in_rst_n,
   input  logic             sig_in_start,
   input  logic             sig_in_abort,
   input  logic             sig_in_valid,
   output logic [SEL_W-1:0] seq_selected,
   output logic             sig_out_load,
   output logic             sig_out_busy,
   output logic             sig_out_done,
   output logic             sig_out_timeout,
   output logic [CNT_W-1:0] sig_out_pass_cnt,
   output logic [CNT_W-1:0] sig_out_tmo_cnt
);

   localparam int                 TMR_W    = tmr_width(TIMEOUT, GAP_CYCLES);
   localparam logic [TMR_W-1:0]   TMO_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0]   GAP_LAST = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(NUM_SEQ - 1);

   state_t             state_r, state_n;
   logic [SEL_W-1:0]   sel_r, sel_n;
   logic [TMR_W-1:0]   timer_r, timer_n;
   logic               tmo_flag_r, tmo_flag_n;
   logic               load_r, busy_r, done_r;
   logic               pass_inc_s, tmo_inc_s, cnt_clr_s;
   logic               seq_last_s;

   assign seq_last_s = (sel_r == SEL_LAST);

   // Next-state, select, timer and counter-strobe logic.
   always_comb begin
      state_n    = state_r;
      sel_n      = sel_r;
      timer_n    = timer_r;
      tmo_flag_n = tmo_flag_r;
      pass_inc_s = 1'b0;
      tmo_inc_s  = 1'b0;
      cnt_clr_s  = 1'b0;
      if (sig_in_abort) begin
         state_n = ST_IDLE;
         timer_n = {TMR_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (sig_in_start) begin
                  state_n    = ST_LOAD;
                  sel_n      = {SEL_W{1'b0}};
                  cnt_clr_s  = 1'b1;
                  tmo_flag_n = 1'b0;
               end else begin
                  state_n = ST_IDLE;
               end
            end
            ST_LOAD: begin
               state_n = ST_WAIT;
               timer_n = {TMR_W{1'b0}};
            end
            ST_WAIT: begin
               // Valid on the final timer cycle still counts as a pass.
               if (sig_in_valid || (timer_r == TMO_LAST)) begin
                  if (sig_in_valid) begin
                     pass_inc_s = 1'b1;
                  end else begin
                     tmo_inc_s  = 1'b1;
                     tmo_flag_n = 1'b1;
                  end
                  if (GAP_CYCLES == 0) begin
                     if (seq_last_s) begin
                        state_n = ST_DONE;
                     end else begin
                        state_n = ST_LOAD;
                        sel_n   = sel_r + SEL_W'(1);
                     end
                  end else begin
                     state_n = ST_GAP;
                     timer_n = {TMR_W{1'b0}};
                  end
               end else begin
                  timer_n = timer_r + TMR_W'(1);
               end
            end
            ST_GAP: begin
               if (timer_r == GAP_LAST) begin
                  if (seq_last_s) begin
                     state_n = ST_DONE;
                  end else begin
                     state_n = ST_LOAD;
                     sel_n   = sel_r + SEL_W'(1);
                  end
               end else begin
                  timer_n = timer_r + TMR_W'(1);
               end
            end
            ST_DONE: begin
`ifdef SEQ_LOOP_EN
               state_n = ST_LOAD;
               sel_n   = {SEL_W{1'b0}};
`else
               if (sig_in_start) begin
                  state_n    = ST_LOAD;
                  sel_n      = {SEL_W{1'b0}};
                  cnt_clr_s  = 1'b1;
                  tmo_flag_n = 1'b0;
               end else begin
                  state_n = ST_DONE;
               end
`endif
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs; strobes are derived from the next state.
   always_ff @(posedge sig_mstr_clk or negedge sig_in_rst_n) begin
      if (!sig_in_rst_n) begin
         state_r    <= ST_IDLE;
         sel_r      <= {SEL_W{1'b0}};
         timer_r    <= {TMR_W{1'b0}};
         tmo_flag_r <= 1'b0;
         load_r     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_n;
         sel_r      <= sel_n;
         timer_r    <= timer_n;
         tmo_flag_r <= tmo_flag_n;
         load_r     <= (state_n == ST_LOAD);
         busy_r     <= (state_n == ST_LOAD) || (state_n == ST_WAIT) || (state_n == ST_GAP);
         done_r     <= (state_n == ST_DONE);
      end
   end

   present_sat_counter #(.W(CNT_W)) u_pass_cnt (
      .clk   (sig_mstr_clk),
      .rst_n (sig_in_rst_n),
      .clr   (cnt_clr_s),
      .inc   (pass_inc_s),
      .cnt   (sig_out_pass_cnt)
   );

   present_sat_counter #(.W(CNT_W)) u_tmo_cnt (
      .clk   (sig_mstr_clk),
      .rst_n (sig_in_rst_n),
      .clr   (cnt_clr_s),
      .inc   (tmo_inc_s),
      .cnt   (sig_out_tmo_cnt)
   );

   assign seq_selected    = sel_r;
   assign sig_out_load    = load_r;
   assign sig_out_busy    = busy_r;
   assign sig_out_done    = done_r;
   assign sig_out_timeout = tmo_flag_r;

endmodule

// File: doc/present_test_sequencer.md
Name: present_test_sequencer

Overview:
Upstream driver for the PRESENT hardware test apparatus. It steps the vector select through 0..NUM_SEQ-1 and issues a one-cycle load pulse per vector. It then waits for the apparatus valid strobe, with a timeout, and counts completed and timed-out vectors. This replaces bench-driven select/load stimulus with a synthesizable on-chip controller.

Parameters:
NUM_SEQ, 32, number of vectors to run per pass (1..2^SEL_W)
SEL_W, 6, width of the seq_selected bus
TIMEOUT, 256, max cycles to wait for valid after load before flagging timeout (>=2)
GAP_CYCLES, 2, idle cycles between valid/timeout and the next load (>=0)
CNT_W, 8, width of the completed/timeout counters (saturating)

Ports:
sig_mstr_clk  in  1  master clock, all state on rising edge
sig_in_rst_n  in  1  asynchronous active-low reset
sig_in_start  in  1  level/pulse; sampled in IDLE or DONE to begin a pass
sig_in_abort  in  1  synchronous abort; returns to IDLE next cycle
sig_in_valid  in  1  valid strobe from the test apparatus (consumed)
seq_selected  out  SEL_W  current vector index to the apparatus
sig_out_load  out  1  one-cycle load pulse to the apparatus
sig_out_busy  out  1  high in LOAD/WAIT/GAP
sig_out_done  out  1  high in DONE until next start or reset
sig_out_timeout  out  1  sticky: any vector in this pass timed out
sig_out_pass_cnt  out  CNT_W  vectors that returned valid this pass
sig_out_tmo_cnt  out  CNT_W  vectors that timed out this pass

Behaviour:
- Reset (async assert, sync-free release): state=IDLE, seq_selected=0, load=0, busy=0, done=0, timeout=0, both counters=0, timer=0.
- All outputs are registered; no combinational input-to-output paths.
- IDLE: if start=1 -> LOAD; clear counters, timeout flag, seq_selected=0.
- LOAD (1 cycle): load=1 with seq_selected stable; timer cleared -> WAIT.
- seq_selected is held constant from LOAD through the end of WAIT; it changes only on the GAP->LOAD transition.
- WAIT: timer increments each cycle. If valid=1 -> pass_cnt+1 -> GAP. Else if timer==TIMEOUT-1 -> tmo_cnt+1, timeout=1 -> GAP. If valid arrives on the timeout cycle itself, it counts as pass.
- Valid is ignored outside WAIT. This covers the LOAD cycle, so a stale valid from a previous vector cannot complete the current one.
- GAP: waits GAP_CYCLES cycles; GAP_CYCLES=0 skips the state. Then, if seq_selected==NUM_SEQ-1 -> DONE; else seq_selected+1 -> LOAD.
- DONE: done=1, busy=0. Counters and seq_selected hold the final values. Start=1 -> behaves as IDLE start (counters cleared, LOAD next).
- Abort in any state except IDLE -> IDLE next cycle, load forced 0, counters held. Abort has priority over start and valid.
- Counters saturate at 2^CNT_W-1; there is no wrap.
- Latency: start sampled at edge N -> load high in cycle N+1.
- Per-vector period = 1 (LOAD) + wait cycles + GAP_CYCLES.
- Reset mid-pass: everything returns to reset values immediately; no partial state is retained.

Optional Feature:
Macro SEQ_LOOP_EN.
- Defined: DONE is not terminal. After one cycle in DONE (done pulses high for 1 cycle), the FSM reloads seq_selected=0 and returns to LOAD. Counters keep accumulating across passes, saturating. Abort is the only exit.
- Undefined: DONE holds as described above.

Decomposition:
- Package present_test_pkg holds:
  - state enum localparams ST_IDLE, ST_LOAD, ST_WAIT, ST_GAP, ST_DONE (3-bit encoding);
  - SEL_W default;
  - default TIMEOUT derivation (4*ROUNDS).
- One natural sub-module, present_sat_counter (width param, clear, inc, saturating), instantiated twice for the pass and timeout counters.
- The timer stays inline.

Test Plan:
- Nominal: NUM_SEQ=4, valid returned 10 cycles after each load -> 4 load pulses with seq_selected 0,1,2,3; pass_cnt=4, tmo_cnt=0, done=1, timeout=0.
- Timeout: valid never asserted for vector 2, TIMEOUT=16 -> WAIT lasts 16 cycles on index 2; tmo_cnt=1, pass_cnt=3, timeout=1, sequencing continues to index 3.
- Boundary: valid asserted exactly on the timer==TIMEOUT-1 cycle -> counted as pass (pass_cnt+1, tmo_cnt unchanged).
- Stale valid: valid held high during LOAD and released before WAIT -> ignored; a later valid in WAIT completes the vector.
- Abort and reset: abort in WAIT at index 5 -> IDLE next cycle, load=0, pass_cnt=5 held. Async reset mid-GAP -> all outputs 0 immediately. New start -> begins at seq_selected=0.
- SEQ_LOOP_EN: NUM_SEQ=2, two full passes -> done pulses once per pass; seq_selected sequence 0,1,0,1; pass_cnt=4.
